// File: rtl/prio_fifo_pkg.sv
// Shared widths and helpers for the multi-priority FIFO.
package prio_fifo_pkg;

    // Default configuration used by the top level
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_PRIO_NUM    = 4;
    localparam int DEF_QADDR_WIDTH = 3;

    // Widths derived from the default configuration
    localparam int PRIO_WIDTH      = $clog2(DEF_PRIO_NUM);
    localparam int PTR_WIDTH       = DEF_QADDR_WIDTH + 1;
    localparam int RAM_ADDR_WIDTH  = PRIO_WIDTH + DEF_QADDR_WIDTH;

    // Index of the lowest set bit (0 when no bit is set)
    function automatic int unsigned lowest_set(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Single-clock simple dual-port RAM with a registered read port.
module sdp_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port; contents are never cleared
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port, holds its value when not reading
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/prio_fifo_ram.sv
// Multi-priority FIFO: per-priority circular queues sharing one SDP RAM,
// dequeue always serves the lowest-index non-empty queue.
module prio_fifo_ram
    import prio_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PRIO_NUM    = DEF_PRIO_NUM,
    parameter int QADDR_WIDTH = DEF_QADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(PRIO_NUM)-1:0] wr_prio,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_drop,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [$clog2(PRIO_NUM)-1:0] rd_prio,
    output logic [PRIO_NUM-1:0]         q_empty,
    output logic [PRIO_NUM-1:0]         q_full
);

    localparam int PW  = $clog2(PRIO_NUM);
    localparam int PTW = QADDR_WIDTH + 1;
    localparam int AW  = PW + QADDR_WIDTH;

    logic [PTW-1:0] wptr_q [PRIO_NUM];
    logic [PTW-1:0] wptr_d [PRIO_NUM];
    logic [PTW-1:0] rptr_q [PRIO_NUM];
    logic [PTW-1:0] rptr_d [PRIO_NUM];

    logic            rd_valid_q, rd_valid_d;
    logic [PW-1:0]   rd_prio_q, rd_prio_d;
    logic            wr_drop_q, wr_drop_d;

    logic [PRIO_NUM-1:0]   empty, full;
    logic                  do_wr, do_rd;
    logic [PW-1:0]         sel;
    logic [AW-1:0]         ram_waddr, ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Per-queue flags from the current (pre-edge) pointers
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < PRIO_NUM; i++) begin
            empty[i] = (wptr_q[i] == rptr_q[i]);
            full[i]  = (wptr_q[i][PTW-1] != rptr_q[i][PTW-1]) &&
                       (wptr_q[i][PTW-2:0] == rptr_q[i][PTW-2:0]);
        end
    end

    assign q_empty = empty;
    assign q_full  = full;

    // Accept/select decisions, RAM addresses and next-state values
    always_comb begin
        do_wr     = wr_en && !full[wr_prio] && !rst;
        do_rd     = rd_en && (~empty != '0) && !rst;
        sel       = PW'(lowest_set(32'(~empty)));
        ram_waddr = {wr_prio, wptr_q[wr_prio][QADDR_WIDTH-1:0]};
        ram_raddr = {sel, rptr_q[sel][QADDR_WIDTH-1:0]};
        for (int i = 0; i < PRIO_NUM; i++) begin
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
        end
        if (do_wr) wptr_d[wr_prio] = wptr_q[wr_prio] + PTW'(1);
        if (do_rd) rptr_d[sel]     = rptr_q[sel] + PTW'(1);
        rd_valid_d = do_rd;
        rd_prio_d  = do_rd ? sel : rd_prio_q;
        wr_drop_d  = wr_en && full[wr_prio] && !rst;
    end

    // Pointer and output-register state
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRIO_NUM; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            rd_valid_q <= 1'b0;
            rd_prio_q  <= '0;
            wr_drop_q  <= 1'b0;
        end else begin
            for (int i = 0; i < PRIO_NUM; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
            rd_valid_q <= rd_valid_d;
            rd_prio_q  <= rd_prio_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    sdp_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (ram_waddr),
        .wr_data (wr_data),
        .rd_en   (do_rd),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata)
    );

    // RAM output register is not reset, so present zero outside valid cycles
    assign rd_data  = rd_valid_q ? ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign rd_prio  = rd_prio_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_prio_fifo_ram.sv
// Directed bench for prio_fifo_ram with a per-queue reference model and
// an output scoreboard.
module tb_prio_fifo_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_prio;
    logic [15:0] wr_data;
    logic        wr_drop;
    logic        rd_en;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [1:0]  rd_prio;
    logic [3:0]  q_empty;
    logic [3:0]  q_full;

    int tests = 0;
    int fails = 0;

    // reference model: per-queue circular buffer
    logic [15:0] mmem [4][8];
    int          cnt  [4];
    int          head [4];
    logic [17:0] sb [$];

    always #5 clk = ~clk;

    prio_fifo_ram #(
        .DATA_WIDTH  (16),
        .PRIO_NUM    (4),
        .QADDR_WIDTH (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_prio  (wr_prio),
        .wr_data  (wr_data),
        .wr_drop  (wr_drop),
        .rd_en    (rd_en),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_prio  (rd_prio),
        .q_empty  (q_empty),
        .q_full   (q_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, update model, check outputs after the edge
    task automatic cyc(input logic r, input logic we, input logic [1:0] wp,
                       input logic [15:0] wd, input logic re);
        logic        exp_vld;
        logic        exp_drop;
        logic        full_pre;
        logic [3:0]  ee;
        logic [3:0]  ff;
        logic [17:0] e;
        int          sel;
        @(negedge clk);
        rst = r; wr_en = we; wr_prio = wp; wr_data = wd; rd_en = re;
        exp_vld  = 1'b0;
        full_pre = (cnt[wp] == 8);
        exp_drop = !r && we && full_pre;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i]  = 0;
                head[i] = 0;
            end
            sb.delete();
        end else begin
            sel = -1;
            for (int i = 0; i < 4; i++)
                if (sel < 0 && cnt[i] > 0) sel = i;
            if (re && sel >= 0) begin
                exp_vld = 1'b1;
                sb.push_back({2'(sel), mmem[sel][head[sel]]});
                head[sel] = (head[sel] + 1) % 8;
                cnt[sel]--;
            end
            if (we && !full_pre) begin
                mmem[wp][(head[wp] + cnt[wp]) % 8] = wd;
                cnt[wp]++;
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
        if (exp_vld && sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e[15:0]));
            chk("rd_prio", 32'(rd_prio), 32'(e[17:16]));
        end
        chk("wr_drop", 32'(wr_drop), 32'(exp_drop));
        for (int i = 0; i < 4; i++) begin
            ee[i] = (cnt[i] == 0);
            ff[i] = (cnt[i] == 8);
        end
        chk("q_empty", 32'(q_empty), 32'(ee));
        chk("q_full", 32'(q_full), 32'(ff));
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_prio = 2'd0; wr_data = 16'h0; rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt[i]  = 0;
            head[i] = 0;
        end

        // reset, then dequeue with nothing queued
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 16'h0, 1'b1);
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_rd_prio", 32'(rd_prio), 32'h0);
        chk("reset_q_empty", 32'(q_empty), 32'hF);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        chk("idle_rd_data", 32'(rd_data), 32'h0);

        // priority selection across two queues
        cyc(1'b0, 1'b1, 2'd2, 16'h00A1, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 16'h00B1, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);

        // fill prio 1, overflow, drain
        for (int i = 0; i < 9; i++)
            cyc(1'b0, 1'b1, 2'd1, 16'h0010 + 16'(i), 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);
        for (int i = 0; i < 9; i++)
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);

        // full prio 3 with simultaneous enqueue and dequeue
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 2'd3, 16'h0300 + 16'(i), 1'b0);
        cyc(1'b0, 1'b1, 2'd3, 16'h0399, 1'b1);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);

        // no bypass: write into empty queue with same-cycle dequeue
        cyc(1'b0, 1'b1, 2'd2, 16'h0055, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b0);

        // pointer wrap on prio 0, then reset mid-stream
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 2'd0, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b1, 2'd0, 16'h0200 + 16'(i), 1'b1);
        cyc(1'b0, 1'b1, 2'd1, 16'h0777, 1'b0);
        cyc(1'b1, 1'b1, 2'd0, 16'h0888, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
        chk("post_reset_q_empty", 32'(q_empty), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
